// File: rtl/mem_read_write_accelerator_addr_gen.sv
// mem_read_write_accelerator_addr_gen: splits a transfer into AXI bursts, strides/wraps addresses, waits for completions
module mem_read_write_accelerator_addr_gen #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 256,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_MAX_BURST_BEATS = 64
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  input  logic [31:0]                  addr_increment,
  input  logic [31:0]                  mem_max_addr,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [C_ADDR_WIDTH-1:0]      cmd_addr,
  output logic [7:0]                   cmd_len,
  output logic                         cmd_last,
  input  logic                         cmpl_valid,
  output logic                         busy,
  output logic                         ctrl_done
);
  localparam int LP_B     = C_DATA_WIDTH / 8;
  localparam int LP_LOG_B = $clog2(LP_B);
  localparam int LP_BW    = C_XFER_SIZE_WIDTH - LP_LOG_B + 1;
  localparam logic [LP_BW-1:0] LP_MAX = LP_BW'(C_MAX_BURST_BEATS);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t                  state;
  logic [LP_BW-1:0]        beats_left, outstanding, total_beats, burst_beats, beats_rem;
  logic [LP_BW-1:0]        next_beats, next_burst, out_nxt;
  logic [C_ADDR_WIDTH-1:0] base;
  logic [31:0]             incr, max_addr, offset, offset_nxt;
  logic [32:0]             offset_sum;
  logic [7:0]              next_len;
  logic                    hs, cmpl_ok;
  always_comb begin
    total_beats = LP_BW'(ctrl_xfer_size_in_bytes >> LP_LOG_B) + LP_BW'(|ctrl_xfer_size_in_bytes[LP_LOG_B-1:0]);
    burst_beats = beats_left < LP_MAX ? beats_left : LP_MAX;
    beats_rem   = beats_left - burst_beats;
    next_beats  = state == IDLE ? total_beats : beats_rem;
    next_burst  = next_beats < LP_MAX ? next_beats : LP_MAX;
    next_len    = next_burst == '0 ? '0 : 8'(next_burst - LP_BW'(1));
    hs          = cmd_valid & cmd_ready;
    cmpl_ok     = cmpl_valid & (outstanding != '0);
    out_nxt     = outstanding + LP_BW'(hs) - LP_BW'(cmpl_ok);
    offset_sum  = {1'b0, offset} + {1'b0, incr};
    // the comparison is done on the 33-bit sum so a stride that overflows 32 bits still wraps
    offset_nxt  = (max_addr != '0 && offset_sum >= {1'b0, max_addr}) ? '0 : offset_sum[31:0];
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      beats_left  <= '0;
      outstanding <= '0;
      base        <= '0;
      incr        <= '0;
      max_addr    <= '0;
      offset      <= '0;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      cmd_last    <= 1'b0;
      busy        <= 1'b0;
      ctrl_done   <= 1'b0;
    end else begin
      ctrl_done   <= 1'b0;
      outstanding <= out_nxt;
      case (state)
        IDLE: if (ctrl_start) begin
          base       <= ctrl_addr_offset;
          incr       <= addr_increment;
          max_addr   <= mem_max_addr;
          beats_left <= total_beats;
          offset     <= '0;
          busy       <= 1'b1;
          if (total_beats == '0) begin
            state     <= DONE;
            ctrl_done <= 1'b1;
          end else begin
            state     <= ISSUE;
            cmd_valid <= 1'b1;
            cmd_addr  <= ctrl_addr_offset;
            cmd_len   <= next_len;
            cmd_last  <= next_beats <= LP_MAX;
          end
        end
        ISSUE: if (hs) begin
          beats_left <= beats_rem;
          offset     <= offset_nxt;
          cmd_addr   <= base + C_ADDR_WIDTH'(offset_nxt);
          cmd_len    <= next_len;
          cmd_last   <= next_beats <= LP_MAX;
          if (cmd_last) begin
            cmd_valid <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: if (out_nxt == '0) begin
          state     <= DONE;
          ctrl_done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
